// File: rtl/gigatron_pkg.sv
// Shared types and constants for the Gigatron boot/loader controller.
package gigatron_pkg;

    localparam int ADDR_W = 16;
    localparam int WORD_W = 16;

    localparam logic [7:0] MAGIC_DEFAULT = 8'h47;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_L,
        ST_ADDR_H,
        ST_CNT_L,
        ST_CNT_H,
        ST_DATA_L,
        ST_DATA_H,
        ST_CHECK,
        ST_HOLD,
        ST_ERROR
    } boot_state_t;

endpackage

// File: rtl/gigatron_boot_if.sv
// Byte-stream input and ROM write port of the boot loader, bundled as one interface.
interface gigatron_boot_if;
    import gigatron_pkg::*;

    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_data;
    logic              rom_we;

    // Host side: drives the stream, observes the ROM write port.
    modport master (
        output s_data, s_valid,
        input  s_ready, rom_addr, rom_data, rom_we
    );

    // Loader side.
    modport slave (
        input  s_data, s_valid,
        output s_ready, rom_addr, rom_data, rom_we
    );

endinterface

// File: rtl/gigatron_boot.sv
// Framed byte-stream loader: writes words into the instruction ROM and holds the CPU in reset.
// Optional trailer checksum enabled with GIGATRON_BOOT_CHECKSUM_EN.
module gigatron_boot
    import gigatron_pkg::*;
#(
    parameter logic [7:0] MAGIC       = MAGIC_DEFAULT,
    parameter int         HOLD_CYCLES = 16
) (
    input  logic           clock,
    input  logic           reset,
    gigatron_boot_if.slave bus,
    output logic           cpu_rst_n,
    output logic           busy,
    output logic           err
);

    localparam logic [15:0] HOLD_M1 = 16'(HOLD_CYCLES - 1);

`ifdef GIGATRON_BOOT_CHECKSUM_EN
    localparam boot_state_t END_ST = ST_CHECK;
`else
    localparam boot_state_t END_ST = ST_HOLD;
`endif

    boot_state_t       state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       cnt_q;
    logic [7:0]        lo_q;
    logic [15:0]       hold_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [WORD_W-1:0] rom_data_q;
    logic              rom_we_q;
    logic              cpu_rst_n_q;
    logic              s_ready_w;
    logic              accept;

`ifdef GIGATRON_BOOT_CHECKSUM_EN
    logic [7:0]        sum_q;
    logic              err_q;
`endif

    assign s_ready_w = (state_q != ST_HOLD);
    assign accept    = bus.s_valid & s_ready_w;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            lo_q        <= '0;
            hold_q      <= HOLD_M1;
            rom_addr_q  <= '0;
            rom_data_q  <= '0;
            rom_we_q    <= 1'b0;
            cpu_rst_n_q <= 1'b1;
`ifdef GIGATRON_BOOT_CHECKSUM_EN
            sum_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            rom_we_q <= 1'b0;
            // Hold counter is preloaded outside HOLD so entry needs no extra branch.
            if (state_q != ST_HOLD) begin
                hold_q <= HOLD_M1;
            end
`ifdef GIGATRON_BOOT_CHECKSUM_EN
            if (accept && (state_q inside {ST_ADDR_L, ST_ADDR_H, ST_CNT_L,
                                           ST_CNT_H, ST_DATA_L, ST_DATA_H})) begin
                sum_q <= sum_q + bus.s_data;
            end
`endif
            case (state_q)
                ST_IDLE, ST_ERROR: begin
                    if (accept && bus.s_data == MAGIC) begin
                        state_q     <= ST_ADDR_L;
                        cpu_rst_n_q <= 1'b0;
`ifdef GIGATRON_BOOT_CHECKSUM_EN
                        sum_q       <= '0;
                        err_q       <= 1'b0;
`endif
                    end
                end
                ST_ADDR_L: if (accept) begin
                    addr_q[7:0] <= bus.s_data;
                    state_q     <= ST_ADDR_H;
                end
                ST_ADDR_H: if (accept) begin
                    addr_q[15:8] <= bus.s_data;
                    state_q      <= ST_CNT_L;
                end
                ST_CNT_L: if (accept) begin
                    cnt_q[7:0] <= bus.s_data;
                    state_q    <= ST_CNT_H;
                end
                ST_CNT_H: if (accept) begin
                    cnt_q[15:8] <= bus.s_data;
                    state_q     <= ({bus.s_data, cnt_q[7:0]} == 16'd0) ? END_ST : ST_DATA_L;
                end
                ST_DATA_L: if (accept) begin
                    lo_q    <= bus.s_data;
                    state_q <= ST_DATA_H;
                end
                ST_DATA_H: if (accept) begin
                    rom_addr_q <= addr_q;
                    rom_data_q <= {bus.s_data, lo_q};
                    rom_we_q   <= 1'b1;
                    addr_q     <= addr_q + 1'b1;
                    cnt_q      <= cnt_q - 1'b1;
                    state_q    <= (cnt_q == 16'd1) ? END_ST : ST_DATA_L;
                end
`ifdef GIGATRON_BOOT_CHECKSUM_EN
                ST_CHECK: if (accept) begin
                    if (bus.s_data == sum_q) begin
                        state_q <= ST_HOLD;
                    end else begin
                        state_q <= ST_ERROR;
                        err_q   <= 1'b1;
                    end
                end
`endif
                ST_HOLD: begin
                    if (hold_q == 16'd0) begin
                        state_q     <= ST_IDLE;
                        cpu_rst_n_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_ready  = s_ready_w;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_data = rom_data_q;
    assign bus.rom_we   = rom_we_q;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign busy         = !(state_q inside {ST_IDLE, ST_ERROR});

`ifdef GIGATRON_BOOT_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gigatron_boot.sv
// Directed table-driven bench for gigatron_boot: frame loads, wrap, empty frames, reset and hold corners.
module tb_gigatron_boot;

    localparam logic [7:0] MAGIC = 8'h47;
    localparam int         HOLD  = 16;

    logic clock = 1'b0;
    logic reset;
    logic cpu_rst_n, busy, err;

    int total = 0;
    int bad   = 0;
    int wr_count = 0;

    gigatron_boot_if bus ();

    gigatron_boot #(.MAGIC(MAGIC), .HOLD_CYCLES(HOLD)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .err       (err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.rom_we === 1'b1) wr_count++;
    end

    typedef struct {
        logic [15:0] addr;
        logic [15:0] cnt;
        logic [15:0] w0;
        logic [15:0] w1;
        bit          bad_sum;
        logic [15:0] exp_a0;
        logic [15:0] exp_a1;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // Offer one byte; returns #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        while (bus.s_ready !== 1'b1 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL ready_wait: s_ready stuck low for %0d cycles, required high", n);
        end
        @(posedge clock); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_release(output int n);
        n = 0;
        while (cpu_rst_n !== 1'b1 && n < 500) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    // Everything after MAGIC: header, words with per-write checks, optional trailer.
    task automatic run_body(input vec_t v);
        logic [7:0]  sum;
        logic [15:0] w, ea;
        sum = v.addr[7:0] + v.addr[15:8] + v.cnt[7:0] + v.cnt[15:8];
        send_byte(v.addr[7:0]);
        send_byte(v.addr[15:8]);
        send_byte(v.cnt[7:0]);
        send_byte(v.cnt[15:8]);
        for (int i = 0; i < int'(v.cnt); i++) begin
            w  = (i == 0) ? v.w0 : v.w1;
            ea = (i == 0) ? v.exp_a0 : v.exp_a1;
            sum = sum + w[7:0] + w[15:8];
            send_byte(w[7:0]);
            send_byte(w[15:8]);
            chk("rom_we", bus.rom_we, 1);
            chk("rom_addr", bus.rom_addr, ea);
            chk("rom_data", bus.rom_data, w);
        end
`ifdef GIGATRON_BOOT_CHECKSUM_EN
        send_byte(v.bad_sum ? 8'h00 : sum);
`endif
    endtask

    task automatic run_frame(input vec_t v);
        int  wr0, n;
        bit  exp_err;
        wr0 = wr_count;
`ifdef GIGATRON_BOOT_CHECKSUM_EN
        exp_err = v.bad_sum;
`else
        exp_err = 1'b0;
`endif
        send_byte(MAGIC);
        chk("rst_low_after_magic", cpu_rst_n, 0);
        chk("busy_in_frame", busy, 1);
        chk("err_cleared", err, 0);
        run_body(v);
        if (exp_err) begin
            chk("err_set", err, 1);
            chk("err_busy", busy, 0);
            chk("err_ready", bus.s_ready, 1);
            repeat (4) begin @(posedge clock); #1; end
            chk("err_rst_held", cpu_rst_n, 0);
            chk("err_sticky", err, 1);
        end else begin
            chk("hold_ready", bus.s_ready, 0);
            wait_release(n);
            chk("hold_cycles", n, HOLD);
            chk("rel_err", err, 0);
            chk("rel_busy", busy, 0);
        end
        chk("write_count", wr_count - wr0, v.cnt);
    endtask

    initial begin
        int n, viol, wr0;
        vec_t v;

        // addr, cnt, w0, w1, bad_sum, exp_a0, exp_a1
        vecs[0] = '{16'h0010, 16'd1, 16'hABCD, 16'h0000, 1'b0, 16'h0010, 16'h0000};
        vecs[1] = '{16'h0010, 16'd1, 16'hABCD, 16'h0000, 1'b1, 16'h0010, 16'h0000};
        vecs[2] = '{16'h0010, 16'd1, 16'hABCD, 16'h0000, 1'b0, 16'h0010, 16'h0000};
        vecs[3] = '{16'hFFFF, 16'd2, 16'h1234, 16'h5678, 1'b0, 16'hFFFF, 16'h0000};
        vecs[4] = '{16'h0100, 16'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[5] = '{16'h8000, 16'd2, 16'hBEEF, 16'h0047, 1'b0, 16'h8000, 16'h8001};

        reset = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        chk("reset_ready", bus.s_ready, 1);
        chk("reset_addr", bus.rom_addr, 0);
        chk("reset_data", bus.rom_data, 0);
        chk("reset_we", bus.rom_we, 0);
        chk("reset_cpu_rst_n", cpu_rst_n, 1);
        chk("reset_busy", busy, 0);
        chk("reset_err", err, 0);

        send_byte(8'h00);
        chk("junk_cpu_rst_n", cpu_rst_n, 1);
        chk("junk_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            $display("vector %0d addr=%04h cnt=%0d", i, vecs[i].addr, vecs[i].cnt);
            run_frame(vecs[i]);
        end

        // Reset while the hi byte of a word is being offered.
        send_byte(MAGIC);
        send_byte(8'h20); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11);
        wr0 = wr_count;
        bus.s_data  = 8'h22;
        bus.s_valid = 1'b1;
        reset       = 1'b1;
        @(posedge clock); #1;
        chk("rst_mid_cpu_rst_n", cpu_rst_n, 1);
        chk("rst_mid_we", bus.rom_we, 0);
        chk("rst_mid_busy", busy, 0);
        reset = 1'b0;
        bus.s_valid = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        chk("rst_mid_no_write", wr_count - wr0, 0);
        chk("rst_mid_addr", bus.rom_addr, 0);

        // s_valid held high with MAGIC throughout HOLD.
        v = '{16'h0030, 16'd1, 16'h5A5A, 16'h0000, 1'b0, 16'h0030, 16'h0000};
        send_byte(MAGIC);
        run_body(v);
        bus.s_data  = MAGIC;
        bus.s_valid = 1'b1;
        n = 0; viol = 0;
        while (cpu_rst_n !== 1'b1 && n < 500) begin
            if (bus.s_ready !== 1'b0) viol++;
            @(posedge clock); #1;
            n++;
        end
        chk("hv_hold_cycles", n, HOLD);
        chk("hv_ready_low", viol, 0);
        chk("hv_release_ready", bus.s_ready, 1);
        @(posedge clock); #1;
        bus.s_valid = 1'b0;
        chk("hv_magic_consumed", cpu_rst_n, 0);
        chk("hv_busy", busy, 1);
        v = '{16'h0040, 16'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        run_body(v);
        wait_release(n);
        chk("hv_second_hold", n, HOLD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
